// File: rtl/util_edge_pkg.sv
// Shared constants for the edge-event arbiter: edge-type encoding and timestamp width.
package util_edge_pkg;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_type_e;

  localparam int unsigned TS_W = 32;

endpackage

// File: rtl/util_edge_detect.sv
// One channel: SYNC_STAGES-deep synchronizer, history flop and a registered
// qualifying-edge pulse with its edge type.
module util_edge_detect
  import util_edge_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter string       C_EDGE_TYPE = "both"
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic det,
  output logic det_type
);

  // Any other C_EDGE_TYPE string leaves both enables low, so no events are produced.
  localparam bit EN_RISE = (C_EDGE_TYPE == "rising") || (C_EDGE_TYPE == "both");
  localparam bit EN_FALL = (C_EDGE_TYPE == "falling") || (C_EDGE_TYPE == "both");

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic                   det_q, det_d;
  edge_type_e             type_q, type_d;
  logic                   rise, fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    hist_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~hist_q;
    fall   = ~sync_q[SYNC_STAGES-1] & hist_q;
    det_d  = (EN_RISE & rise) | (EN_FALL & fall);
    type_d = fall ? EDGE_FALL : EDGE_RISE;
    // Preloading every stage with din keeps reset release free of spurious edges.
    if (!rstn) begin
      sync_d = {SYNC_STAGES{din}};
      hist_d = din;
      det_d  = 1'b0;
      type_d = EDGE_RISE;
    end
  end

  always_ff @(posedge clk) begin
    sync_q <= sync_d;
    hist_q <= hist_d;
    det_q  <= det_d;
    type_q <= type_d;
  end

  assign det      = det_q;
  assign det_type = type_q;

endmodule

// File: rtl/util_edge_event_arbiter.sv
// Edge-event arbiter: per-channel edge capture, round-robin grant into a
// valid/ready output register. Optional timestamps via UTIL_EDGE_TIMESTAMP_EN.
module util_edge_event_arbiter
  import util_edge_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter string       C_EDGE_TYPE = "both"
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [NUM_CH-1:0]         din,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [$clog2(NUM_CH)-1:0] ev_ch,
  output logic                      ev_edge,
  output logic [NUM_CH-1:0]         ovf,
  input  logic [NUM_CH-1:0]         ovf_clr
`ifdef UTIL_EDGE_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]           ev_ts
`endif
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] det, det_type;
  logic [NUM_CH-1:0] pending_q, pending_d, etype_q, etype_d, ovf_q, ovf_d, pset;
  logic              ev_valid_q, ev_valid_d, ev_edge_q, ev_edge_d;
  logic [CH_W-1:0]   ev_ch_q, ev_ch_d, ptr_q, ptr_d, sel;
  logic              found, load, grant;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    util_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES),
      .C_EDGE_TYPE(C_EDGE_TYPE)
    ) u_detect (
      .clk     (clk),
      .rstn    (rstn),
      .din     (din[g]),
      .det     (det[g]),
      .det_type(det_type[g])
    );
  end

  always_comb begin
    int unsigned idx;
    sel   = ptr_q;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(ptr_q) + k) % NUM_CH;
      if (!found && pending_q[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
    load = (!ev_valid_q || ev_ready) && found;

    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    ev_edge_d  = ev_edge_q;
    ptr_d      = ptr_q;
    if (load) begin
      ev_valid_d = 1'b1;
      ev_ch_d    = sel;
      ev_edge_d  = etype_q[sel];
      ptr_d      = sel;
    end else if (ev_ready) begin
      ev_valid_d = 1'b0;
    end

    etype_d = etype_q;
    // A channel being granted this cycle frees its slot, so a coinciding edge re-arms it.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      grant        = load && (sel == CH_W'(i));
      pset[i]      = det[i] && (!pending_q[i] || grant);
      pending_d[i] = pset[i] | (pending_q[i] & ~grant);
      ovf_d[i]     = (det[i] && pending_q[i] && !grant) | (ovf_q[i] & ~ovf_clr[i]);
      if (pset[i]) etype_d[i] = det_type[i];
    end

    if (!rstn) begin
      pending_d  = '0;
      etype_d    = '0;
      ovf_d      = '0;
      ev_valid_d = 1'b0;
      ev_ch_d    = '0;
      ev_edge_d  = EDGE_RISE;
      ptr_d      = CH_W'(NUM_CH - 1);
    end
  end

  always_ff @(posedge clk) begin
    pending_q  <= pending_d;
    etype_q    <= etype_d;
    ovf_q      <= ovf_d;
    ev_valid_q <= ev_valid_d;
    ev_ch_q    <= ev_ch_d;
    ev_edge_q  <= ev_edge_d;
    ptr_q      <= ptr_d;
  end

  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign ev_edge  = ev_edge_q;
  assign ovf      = ovf_q;

`ifdef UTIL_EDGE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d, ev_ts_q, ev_ts_d;
  logic [TS_W-1:0] ts_cap_q [NUM_CH];
  logic [TS_W-1:0] ts_cap_d [NUM_CH];

  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
    ts_cap_d = ts_cap_q;
    ev_ts_d  = ev_ts_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pset[i]) ts_cap_d[i] = ts_cnt_q;
    end
    if (load) ev_ts_d = ts_cap_q[sel];
    if (!rstn) begin
      ts_cnt_d = '0;
      ts_cap_d = '{default: '0};
      ev_ts_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    ts_cnt_q <= ts_cnt_d;
    ts_cap_q <= ts_cap_d;
    ev_ts_q  <= ev_ts_d;
  end

  assign ev_ts = ev_ts_q;
`endif

endmodule

// File: tb/tb_util_edge_event_arbiter.sv
// Self-checking bench for util_edge_event_arbiter (NUM_CH=4, SYNC_STAGES=2, "both").
module tb_util_edge_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [N-1:0] din = '0;
  logic         ev_ready = 1'b0;
  logic [N-1:0] ovf_clr = '0;
  logic         ev_valid;
  logic [1:0]   ev_ch;
  logic         ev_edge;
  logic [N-1:0] ovf;
`ifdef UTIL_EDGE_TIMESTAMP_EN
  logic [31:0]  ev_ts;
`endif

  util_edge_event_arbiter #(
    .NUM_CH     (N),
    .SYNC_STAGES(2),
    .C_EDGE_TYPE("both")
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .din     (din),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_ch   (ev_ch),
    .ev_edge (ev_edge),
    .ovf     (ovf),
    .ovf_clr (ovf_clr)
`ifdef UTIL_EDGE_TIMESTAMP_EN
    ,
    .ev_ts   (ev_ts)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Event-level model: a sampled din edge becomes pending 3 clocks after it is sampled.
  logic [N-1:0] hist [4];
  bit           m_valid;
  int           m_ch;
  bit           m_edge;
  bit   [N-1:0] m_pend, m_et, m_ovf;
  int           m_ptr;
  int unsigned  m_cnt, m_ts;
  int unsigned  m_cap [N];

  task model_step();
    logic [N-1:0] newe, newv;
    int g;
    if (!rstn) begin
      m_valid = 0; m_ch = 0; m_edge = 0; m_pend = '0; m_et = '0; m_ovf = '0;
      m_ptr = N - 1; m_cnt = 0; m_ts = 0;
      for (int i = 0; i < N; i++) m_cap[i] = 0;
      for (int h = 0; h < 4; h++) hist[h] = din;
      return;
    end
    newe = hist[2] ^ hist[3];
    newv = hist[2];
    g = -1;
    if (!m_valid || ev_ready)
      for (int d = 1; d <= N; d++)
        if (g < 0 && m_pend[(m_ptr + d) % N]) g = (m_ptr + d) % N;
    if (g >= 0) begin
      m_valid = 1; m_ch = g; m_edge = m_et[g]; m_ptr = g; m_pend[g] = 0; m_ts = m_cap[g];
    end else if (ev_ready) begin
      m_valid = 0;
    end
    m_ovf = m_ovf & ~ovf_clr;
    for (int i = 0; i < N; i++) begin
      if (newe[i]) begin
        if (m_pend[i]) m_ovf[i] = 1;
        else begin
          m_pend[i] = 1; m_et[i] = ~newv[i]; m_cap[i] = m_cnt;
        end
      end
    end
    m_cnt++;
    for (int h = 3; h > 0; h--) hist[h] = hist[h-1];
    hist[0] = din;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      chk("model_valid", ev_valid, m_valid);
      chk("model_ovf", ovf, m_ovf);
      if (m_valid) begin
        chk("model_ch", ev_ch, m_ch);
        chk("model_edge", ev_edge, m_edge);
`ifdef UTIL_EDGE_TIMESTAMP_EN
        chk("model_ts", ev_ts, m_ts);
`endif
      end
    end
  end

  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_ev(input string name, input logic [1:0] ch, input logic edg);
    chk({name, "_valid"}, ev_valid, 1'b1);
    chk({name, "_ch"}, ev_ch, ch);
    chk({name, "_edge"}, ev_edge, edg);
  endtask

  initial begin
    wn(3);
    chk("reset_valid", ev_valid, 0);
    chk("reset_ovf", ovf, 0);
    rstn = 1'b1;
    wn(2);

    // single rising edge on ch2: visible 4 clocks after sampling, one cycle only
    ev_ready = 1'b1;
    din = 4'b0100;
    wn(4); chk("lat_early", ev_valid, 0);
    wn(1); chk_ev("lat", 2'd2, 1'b0);
    wn(1); chk("lat_done", ev_valid, 0);

    // re-reset with din held so the pointer restarts at NUM_CH-1
    rstn = 1'b0; wn(2); rstn = 1'b1; wn(2);

    // simultaneous rises on ch0, ch1, ch3
    din = 4'b1111;
    wn(4); chk("b2b_early", ev_valid, 0);
    wn(1); chk_ev("b2b0", 2'd0, 1'b0);
    wn(1); chk_ev("b2b1", 2'd1, 1'b0);
    wn(1); chk_ev("b2b3", 2'd3, 1'b0);
    wn(1); chk("b2b_done", ev_valid, 0);

    // stall: ch1 presented, ch1 rise pending, then ch1 fall + ch2 fall
    ev_ready = 1'b0;
    din = 4'b1101;
    wn(5); chk_ev("stall_first", 2'd1, 1'b1);
    din = 4'b1111;
    wn(2); din = 4'b1001;
    wn(5);
    chk("ovf_set", ovf, 4'b0010);
    chk_ev("stall_hold", 2'd1, 1'b1);
    // overflow set coinciding with clear: set wins
    din = 4'b1011;
    wn(3); ovf_clr = 4'b0010;
    wn(1); ovf_clr = 4'b0000;
    chk("ovf_set_wins", ovf, 4'b0010);
    chk_ev("stall_hold2", 2'd1, 1'b1);
    ev_ready = 1'b1;
    wn(1); chk_ev("drain_ch2", 2'd2, 1'b1);
    wn(1); chk_ev("drain_ch1", 2'd1, 1'b0);
    wn(1); chk("drain_done", ev_valid, 0);
    ovf_clr = 4'b0010;
    wn(1); ovf_clr = 4'b0000;
    chk("ovf_clr", ovf, 4'b0000);

    // move pointer to ch2, then ch1 and ch3 together: ch3 wins by wrap order
    din = 4'b1111;
    wn(5); chk_ev("ptr2", 2'd2, 1'b0);
    wn(1);
    din = 4'b0101;
    wn(5); chk_ev("wrap_ch3", 2'd3, 1'b1);
    wn(1); chk_ev("wrap_ch1", 2'd1, 1'b1);
    wn(1); chk("wrap_done", ev_valid, 0);

    // reset mid-handshake with ch0 still pending, din=F across release
    ev_ready = 1'b0;
    din = 4'b1100;
    wn(5); chk_ev("pre_rst", 2'd3, 1'b0);
    rstn = 1'b0; din = 4'hF;
    wn(1); chk("rst_discard", ev_valid, 0);
    wn(2); rstn = 1'b1;
    ev_ready = 1'b1;
    wn(8);
    chk("no_spurious", ev_valid, 0);
    chk("no_spurious_ovf", ovf, 0);

`ifdef UTIL_EDGE_TIMESTAMP_EN
    // ch0 becomes pending when the counter reads 100; granted only after ch1 is accepted
    ev_ready = 1'b0;
    rstn = 1'b0; wn(2); rstn = 1'b1;
    wn(90); din = 4'hD;
    wn(7);  din = 4'hC;
    wn(10); chk_ev("ts_hold", 2'd1, 1'b1);
    ev_ready = 1'b1;
    wn(1); chk_ev("ts_ch0", 2'd0, 1'b1);
    chk("ts_value", ev_ts, 32'd100);
    wn(2);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
